// File: rtl/zxjoy_pkg.sv
// Shared definitions for the ZX joystick port logic.
// The joystick vector is 11 bits wide and active-high. The named constants
// give the bit position of each direction and button.
package zxjoy_pkg;

  localparam int JOY_WIDTH = 11;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE3 = 5;
  localparam int JOY_FIRE2 = 6;
  localparam int JOY_FIRE  = 7;
  localparam int JOY_START = 10;

  // Highest valid joystick bit index as a map nibble. Any nibble above this
  // value drops its channel.
  localparam logic [3:0] JOY_LAST_IDX = 4'd10;

  // Default button order is btn[4:0] = {fire, up, down, left, right}.
  localparam logic [19:0] DEFAULT_BTN_MAP = {4'd7, 4'd3, 4'd2, 4'd1, 4'd0};

  // By default only the fire bit repeats under autofire.
  localparam logic [JOY_WIDTH-1:0] DEFAULT_AUTOFIRE_MASK = 11'h080;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: a 2-flop synchroniser followed by a stability counter.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronised
// samples that differ from the current stable level. Any sample equal to the
// stable level restarts the count from zero.
//
// Ports:
//   clk_peripheral  peripheral clock
//   reset_n         asynchronous, active-low reset
//   raw             button level after polarity correction, asynchronous
//   stable          debounced level
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_peripheral,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/btn_jstk_debounce.sv
// Board push-buttons to ZX joystick vector.
// Each raw button is polarity-corrected, synchronised and debounced, then
// placed onto the 11-bit joystick vector through BTN_MAP (nibble i selects
// the joystick bit for btn[i]). Buttons sharing a bit are ORed, and nibbles
// above 10 drop their channel. Selected bits can autofire with a square wave
// of half-period AUTOFIRE_HALF that always starts in the "on" phase.
//
// Ports:
//   clk_peripheral    peripheral clock
//   reset_n           asynchronous, active-low reset
//   btn               raw button levels, asynchronous
//   autofire_en       synchronous autofire enable
//   joystick          registered joystick vector, active-high
//   joystick_changed  one-cycle pulse whenever joystick takes a new value
module btn_jstk_debounce
  import zxjoy_pkg::*;
#(
  parameter int                     NUM_BTN         = 5,
  parameter logic [NUM_BTN*4-1:0]   BTN_MAP         = DEFAULT_BTN_MAP,
  parameter bit                     BTN_ACTIVE_LOW  = 1'b0,
  parameter int                     DEBOUNCE_CYCLES = 50000,
  parameter int                     AUTOFIRE_HALF   = 2500000,
  parameter logic [JOY_WIDTH-1:0]   AUTOFIRE_MASK   = DEFAULT_AUTOFIRE_MASK
) (
  input  logic                 clk_peripheral,
  input  logic                 reset_n,
  input  logic [NUM_BTN-1:0]   btn,
  input  logic                 autofire_en,
  output logic [JOY_WIDTH-1:0] joystick,
  output logic                 joystick_changed
);

  localparam int AW = $clog2(AUTOFIRE_HALF + 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_HALF - 1);

  logic [NUM_BTN-1:0]   raw;
  logic [NUM_BTN-1:0]   stable;

  logic [JOY_WIDTH-1:0] map_q, map_d;
  logic [JOY_WIDTH-1:0] fire_mask;
  logic                 hold;
  logic [AW-1:0]        af_cnt_q, af_cnt_d;
  logic                 af_phase_q, af_phase_d;
  logic [JOY_WIDTH-1:0] joy_q, joy_d;
  logic                 changed_q, changed_d;
  logic [3:0]           nib;

  assign raw = btn ^ {NUM_BTN{BTN_ACTIVE_LOW}};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_peripheral(clk_peripheral),
      .reset_n       (reset_n),
      .raw           (raw[g]),
      .stable        (stable[g])
    );
  end

  // Scatter the debounced channels onto joystick bits.
  always_comb begin
    map_d = '0;
    nib   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      nib = BTN_MAP[i*4 +: 4];
      if (nib <= JOY_LAST_IDX) begin
        map_d[nib] = map_d[nib] | stable[i];
      end
    end
  end

  // Autofire: the phase generator runs only while some masked bit is held
  // with autofire enabled, and otherwise sits at count 0 / phase on, so every
  // fresh hold starts with a full "on" half-period.
  always_comb begin
    fire_mask  = autofire_en ? AUTOFIRE_MASK : '0;
    hold       = |(map_q & fire_mask);
    af_cnt_d   = '0;
    af_phase_d = 1'b1;
    if (hold) begin
      af_phase_d = af_phase_q;
      if (af_cnt_q == AF_LAST) begin
        af_phase_d = ~af_phase_q;
      end else begin
        af_cnt_d = af_cnt_q + 1'b1;
      end
    end
    joy_d     = map_q & (~fire_mask | {JOY_WIDTH{af_phase_q}});
    changed_d = (joy_d != joy_q);
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      map_q      <= '0;
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
      joy_q      <= '0;
      changed_q  <= 1'b0;
    end else begin
      map_q      <= map_d;
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
      joy_q      <= joy_d;
      changed_q  <= changed_d;
    end
  end

  assign joystick         = joy_q;
  assign joystick_changed = changed_q;

endmodule

// File: tb/tb_btn_jstk_debounce.sv
// Directed bench for btn_jstk_debounce. Four instances cover the default
// map, active-low inputs, fast autofire and a shared custom map. Each
// expected {joystick_changed, joystick} value is pushed on exp_q as the step
// is driven and popped one per clock, sampled 1 time unit after the edge.
module tb_btn_jstk_debounce;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic [4:0]  btn_a = 5'h1F;
  logic [4:0]  btn_b = 5'h1F;
  logic [4:0]  btn_c = 5'h00;
  logic [1:0]  btn_d = 2'b00;
  logic        af_a = 1'b0, af_b = 1'b0, af_c = 1'b1, af_d = 1'b0;
  logic [10:0] joy_a, joy_b, joy_c, joy_d;
  logic        chg_a, chg_b, chg_c, chg_d;

  btn_jstk_debounce #(.DEBOUNCE_CYCLES(4)) dut_a (
    .clk_peripheral(clk), .reset_n(reset_n), .btn(btn_a),
    .autofire_en(af_a), .joystick(joy_a), .joystick_changed(chg_a));

  btn_jstk_debounce #(.BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4)) dut_b (
    .clk_peripheral(clk), .reset_n(reset_n), .btn(btn_b),
    .autofire_en(af_b), .joystick(joy_b), .joystick_changed(chg_b));

  btn_jstk_debounce #(.DEBOUNCE_CYCLES(1), .AUTOFIRE_HALF(3)) dut_c (
    .clk_peripheral(clk), .reset_n(reset_n), .btn(btn_c),
    .autofire_en(af_c), .joystick(joy_c), .joystick_changed(chg_c));

  btn_jstk_debounce #(.NUM_BTN(2), .BTN_MAP(8'hAA), .DEBOUNCE_CYCLES(4)) dut_d (
    .clk_peripheral(clk), .reset_n(reset_n), .btn(btn_d),
    .autofire_en(af_d), .joystick(joy_d), .joystick_changed(chg_d));

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [11:0] observe(input int sel);
    case (sel)
      0:       return {chg_a, joy_a};
      1:       return {chg_b, joy_b};
      2:       return {chg_c, joy_c};
      default: return {chg_d, joy_d};
    endcase
  endfunction

  // One clock: pop the oldest expectation and compare it with the DUT.
  task automatic tick(input int sel, input string tag);
    logic [11:0] exp_v, got_v;
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = observe(sel);
    checks++;
    assert (got_v === exp_v) else begin
      failures++;
      $error("FAIL %s: observed chg/joy=%h expected=%h", tag, got_v, exp_v);
    end
  endtask

  // Push n copies of one expected value and consume them clock by clock.
  task automatic expect_ticks(input int sel, input string tag,
                              input logic chg, input logic [10:0] joy,
                              input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({chg, joy});
      tick(sel, tag);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held with all buttons pressed: outputs stay clear.
    expect_ticks(0, "reset_hold", 1'b0, 11'h000, 3);
    reset_n = 1'b1;
    expect_ticks(0, "reset_rel_wait", 1'b0, 11'h000, 7);
    expect_ticks(0, "reset_rel_edge7", 1'b1, 11'h08F, 1);
    expect_ticks(0, "reset_rel_hold", 1'b0, 11'h08F, 1);

    // Release everything.
    btn_a = 5'h00;
    expect_ticks(0, "release_wait", 1'b0, 11'h08F, 7);
    expect_ticks(0, "release_edge", 1'b1, 11'h000, 1);
    expect_ticks(0, "release_hold", 1'b0, 11'h000, 2);

    // Press right.
    btn_a[0] = 1'b1;
    expect_ticks(0, "right_wait", 1'b0, 11'h000, 7);
    expect_ticks(0, "right_edge", 1'b1, 11'h001, 1);
    expect_ticks(0, "right_hold", 1'b0, 11'h001, 3);
    btn_a[0] = 1'b0;
    expect_ticks(0, "right_rel_wait", 1'b0, 11'h001, 7);
    expect_ticks(0, "right_rel_edge", 1'b1, 11'h000, 1);
    expect_ticks(0, "right_rel_hold", 1'b0, 11'h000, 1);

    // Bounce on up: 3-cycle highs with 1-cycle lows never get accepted.
    for (int r = 0; r < 4; r++) begin
      btn_a[3] = 1'b1;
      expect_ticks(0, "bounce_high", 1'b0, 11'h000, 3);
      btn_a[3] = 1'b0;
      expect_ticks(0, "bounce_low", 1'b0, 11'h000, 1);
    end
    btn_a[3] = 1'b1;
    expect_ticks(0, "up_wait", 1'b0, 11'h000, 7);
    expect_ticks(0, "up_edge", 1'b1, 11'h008, 1);
    expect_ticks(0, "up_hold", 1'b0, 11'h008, 1);
    btn_a[3] = 1'b0;
    expect_ticks(0, "up_rel_wait", 1'b0, 11'h008, 7);
    expect_ticks(0, "up_rel_edge", 1'b1, 11'h000, 1);

    // Active-low instance: idle high reads as nothing pressed.
    expect_ticks(1, "alow_idle", 1'b0, 11'h000, 2);
    btn_b[4] = 1'b0;
    expect_ticks(1, "alow_wait", 1'b0, 11'h000, 7);
    expect_ticks(1, "alow_edge", 1'b1, 11'h080, 1);
    expect_ticks(1, "alow_hold", 1'b0, 11'h080, 1);

    // Autofire, half-period 3, debounce 1.
    btn_c[4] = 1'b1;
    expect_ticks(2, "af_wait", 1'b0, 11'h000, 4);
    expect_ticks(2, "af_on1_edge", 1'b1, 11'h080, 1);
    expect_ticks(2, "af_on1", 1'b0, 11'h080, 2);
    expect_ticks(2, "af_off1_edge", 1'b1, 11'h000, 1);
    expect_ticks(2, "af_off1", 1'b0, 11'h000, 2);
    expect_ticks(2, "af_on2_edge", 1'b1, 11'h080, 1);
    expect_ticks(2, "af_on2", 1'b0, 11'h080, 2);
    expect_ticks(2, "af_off2_edge", 1'b1, 11'h000, 1);
    expect_ticks(2, "af_off2", 1'b0, 11'h000, 1);
    af_c = 1'b0;
    expect_ticks(2, "af_drop_edge", 1'b1, 11'h080, 1);
    expect_ticks(2, "af_drop_hold", 1'b0, 11'h080, 2);
    btn_c[4] = 1'b0;
    expect_ticks(2, "af_rel_wait", 1'b0, 11'h080, 4);
    expect_ticks(2, "af_rel_edge", 1'b1, 11'h000, 1);

    // Two buttons both mapped to START.
    btn_d = 2'b01;
    expect_ticks(3, "map_b0_wait", 1'b0, 11'h000, 7);
    expect_ticks(3, "map_b0_edge", 1'b1, 11'h400, 1);
    btn_d = 2'b11;
    expect_ticks(3, "map_both_hold", 1'b0, 11'h400, 9);
    btn_d = 2'b10;
    expect_ticks(3, "map_b1_hold", 1'b0, 11'h400, 9);
    btn_d = 2'b00;
    expect_ticks(3, "map_rel_wait", 1'b0, 11'h400, 7);
    expect_ticks(3, "map_rel_edge", 1'b1, 11'h000, 1);
    btn_d = 2'b11;
    expect_ticks(3, "map_pair_wait", 1'b0, 11'h000, 7);
    expect_ticks(3, "map_pair_edge", 1'b1, 11'h400, 1);
    btn_d = 2'b00;
    expect_ticks(3, "map_pair_rel_wait", 1'b0, 11'h400, 7);
    expect_ticks(3, "map_pair_rel_edge", 1'b1, 11'h000, 1);

    // Reset in the middle of a debounce count discards the partial count.
    btn_a[1] = 1'b1;
    expect_ticks(0, "midrst_pre", 1'b0, 11'h000, 3);
    reset_n = 1'b0;
    expect_ticks(0, "midrst_in", 1'b0, 11'h000, 1);
    reset_n = 1'b1;
    expect_ticks(0, "midrst_wait", 1'b0, 11'h000, 7);
    expect_ticks(0, "midrst_edge", 1'b1, 11'h002, 1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
